// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: round-robin share of one single-port memory between the
// Y86 fetch and data requesters, with registered one-cycle ready pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_DONE_I = 3'd3,
    S_DONE_D = 3'd4
  } state_t;

  state_t              state_q;
  logic                last_d_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ready_q;
  logic                d_ready_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic pick_i;
  logic pick_d;

  // On a tie the port that did not win last time is served.
  assign pick_i = i_req && (!d_req || last_d_q);
  assign pick_d = d_req && !pick_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          if (pick_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            last_d_q    <= 1'b0;
            state_q     <= S_BUSY_I;
          end else if (pick_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            last_d_q    <= 1'b1;
            state_q     <= S_BUSY_D;
          end else begin
            mem_req_q <= 1'b0;
          end
        end
        S_BUSY_I: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            i_rdata_q <= mem_rdata;
            i_ready_q <= 1'b1;
            state_q   <= S_DONE_I;
          end
        end
        S_BUSY_D: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
            d_ready_q <= 1'b1;
            state_q   <= S_DONE_D;
          end
        end
        S_DONE_I: begin
          i_ready_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        S_DONE_D: begin
          d_ready_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the data-access requester of the microcoded Y86 core.
- Generates the registered one-cycle `i_ready` and `d_ready` pulses. These drive the microsequencer's IMemReady and DMemReady inputs, so a stalled microstate advances only on the pulse.
- Arbitrates between the two requesters, holds the memory request stable until the memory acknowledges, and captures read data.

Parameters:
- ADDR_W, 16, byte-address width shared by both requesters and the memory port.
- DATA_W, 64, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request; level, held until i_ready.
- i_addr  input  ADDR_W  fetch address; stable while i_req=1.
- i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  DATA_W  fetched word; holds value until next fetch completes.
- d_req  input  1  data request; level, held until d_ready.
- d_we  input  1  1=write, 0=read; stable while d_req=1.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_ready  output  1  one-cycle pulse: data access complete.
- d_rdata  output  DATA_W  read word; updated on read completion only.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  memory completion; one cycle, any latency ≥1 cycle after mem_req.
- mem_rdata  input  DATA_W  valid in the mem_ack cycle.

Behaviour:
- Reset (async, resetn=0): state=IDLE, last_grant=D. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D. All outputs are registered.
- IDLE:
  - Samples i_req and d_req.
  - Only one request high: grant it.
  - Both high: grant the port not in last_grant (round-robin). After reset, fetch wins the first tie.
  - On grant: register mem_addr, mem_we (0 for fetch, d_we for data) and mem_wdata (d_wdata for data; 0 for fetch). Set mem_req=1, update last_grant, go to BUSY_x.
  - Neither high: stay in IDLE, mem_req=0.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - mem_ack=0: stay.
  - mem_ack=1: mem_req=0 next cycle, go to DONE_x, set x_ready=1 next cycle.
  - BUSY_I or a read in BUSY_D: capture mem_rdata into i_rdata or d_rdata.
  - Write completion leaves d_rdata unchanged.
- DONE_x:
  - x_ready=1 for exactly this cycle; mem_req=0.
  - Next state is always IDLE; x_ready clears.
  - Requests are not sampled in DONE. A requester still holding req in the ready cycle is therefore not re-granted for the same access.
- Minimum service latency is 3 cycles from req high in IDLE to x_ready: grant edge, mem_ack in BUSY, ready in DONE. With zero memory wait this gives back-to-back throughput of one access per 3 cycles.
- Requester rules:
  - Each requester deasserts req in the cycle after its ready pulse, or keeps it high to start a new access.
  - A new access is granted in IDLE against the round-robin pointer.
- mem_ack outside BUSY states is ignored: no state change, no data capture.
- i_ready and d_ready are never high in the same cycle. mem_req is never high in DONE or IDLE.
- Req deasserted while BUSY: the memory access still completes and the ready pulse is still issued. Requesters must not withdraw requests.
- Reset mid-access: mem_req drops immediately (async) and any pending ready is lost. The memory must tolerate an abandoned request.
- Address and data widths pass through unchanged; no arithmetic.

Test Plan:
- Reset, then i_req=1, i_addr=0x0010; memory acks 2 cycles after mem_req with 0x0123456789ABCDEF -> mem_addr=0x0010, mem_we=0; i_ready pulses once with i_rdata=0x0123456789ABCDEF; d_ready stays 0.
- i_req and d_req both raised in the same cycle after reset (d_we=1, d_addr=0x0200, d_wdata=0xAA) -> fetch granted first. After i_ready, the data write is granted with mem_we=1, mem_addr=0x0200, mem_wdata=0xAA. After d_ready, d_rdata is unchanged.
- Both requesters held continuously with zero-wait memory (ack one cycle after grant) -> grants alternate I,D,I,D; ready pulse every 3 cycles; never both readies in one cycle.
- mem_ack pulsed while in IDLE with mem_rdata=0xFFFF -> no state change; i_rdata and d_rdata unchanged; no ready pulse.
- Data read at 0x0040 with memory wait of 10 cycles -> mem_req, mem_addr and mem_we held stable for all 10 cycles; d_ready pulse and d_rdata capture on cycle 12 after grant.
- resetn asserted low while in BUSY_D -> mem_req falls in the same cycle without a clock edge; after release state is IDLE and the next tie goes to fetch.
